// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the VGA timing generator family.
// Holds the stock 640x480@60 and 800x600@60 porch/sync/active sets and a helper
// that sums one axis into its total line/frame length.
package vga_timing_pkg;

  // One axis (horizontal in pixels or vertical in lines) of a raster timing set.
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  localparam axis_timing_t H_640X480 = '{active: 640, fp: 16, sync: 96,  bp: 48};
  localparam axis_timing_t V_640X480 = '{active: 480, fp: 10, sync: 2,   bp: 33};
  localparam axis_timing_t H_800X600 = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam axis_timing_t V_800X600 = '{active: 600, fp: 1,  sync: 4,   bp: 23};

  // Total period of one axis: visible region plus all blanking.
  function automatic int timing_total(input axis_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/pix_ce_div.sv
// Pixel-rate clock enable: one-clk ce pulse every CLK_DIV clks (constant 1 when CLK_DIV=1).
// Latency: after reset release the first ce is high during the CLK_DIV-th clk.
// Backpressure: none, free-running.
module pix_ce_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic ce
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;

  // Wrap the divider at CLK_DIV-1.
  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + DW'(1);
  end

  // ce is registered as the decode of the next divider value, so it is high exactly while div==CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div <= '0;
      ce  <= (CLK_DIV == 1);
    end else begin
      div <= div_nxt;
      ce  <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, data enable, pixel coordinates, line/frame strobes.
// Latency: all outputs registered, updated on the pix_ce edge together with x/y; strobes 1 clk wide.
// Backpressure: none, free-running. Optional frame counter port enabled by `VGA_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_640X480.active,
  parameter int H_FP     = H_640X480.fp,
  parameter int H_SYNC   = H_640X480.sync,
  parameter int H_BP     = H_640X480.bp,
  parameter int V_ACTIVE = V_640X480.active,
  parameter int V_FP     = V_640X480.fp,
  parameter int V_SYNC   = V_640X480.sync,
  parameter int V_BP     = V_640X480.bp,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 4,
  localparam int H_TOTAL = timing_total(axis_timing_t'{H_ACTIVE, H_FP, H_SYNC, H_BP}),
  localparam int V_TOTAL = timing_total(axis_timing_t'{V_ACTIVE, V_FP, V_SYNC, V_BP}),
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CLK_DIV < 1) begin : g_param_err
    $error("vga_timing_gen: every H_*/V_* timing value and CLK_DIV must be >= 1");
  end

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_FIRST = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_FIRST = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_ON    = (H_POL != 0);
  localparam logic          VS_ON    = (V_POL != 0);

  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          de_nxt;
  logic          hs_act;
  logic          vs_act;

  pix_ce_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_ce_div (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (pix_ce)
  );

  // Next raster position and its decode; registering the decode keeps x, y, de and syncs skew-free.
  always_comb begin
    x_nxt = x + XW'(1);
    y_nxt = y;
    if (x == X_LAST) begin
      x_nxt = '0;
      y_nxt = (y == Y_LAST) ? '0 : y + YW'(1);
    end
    de_nxt = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
    hs_act = (x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST);
    vs_act = (y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST);
  end

  // Position/decode registers advance on pix_ce; strobes clear on every other clk so they stay 1 clk wide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x           <= X_LAST;
      y           <= Y_LAST;
      de          <= 1'b0;
      hsync       <= !HS_ON;
      vsync       <= !VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        x           <= x_nxt;
        y           <= y_nxt;
        de          <= de_nxt;
        hsync       <= hs_act ? HS_ON : !HS_ON;
        vsync       <= vs_act ? VS_ON : !VS_ON;
        line_start  <= (x_nxt == '0);
        frame_start <= (x_nxt == '0) && (y_nxt == '0);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Count frames started; bumps on the clk after each frame_start pulse and wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
